// File: rtl/fp_accumulate_if.sv
// fp_accumulate_if: stream handshake bundle for fp_accumulate.
// Input element channel (valid/ready/data/last) and result channel (valid/ready/data/count/ovf).
interface fp_accumulate_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/fp_accumulate.sv
// fp_accumulate: [s][e][m] stream accumulator, one packet -> one sum.
// Ports: clock, clock_areset_n (async low), clear (sync abort), bus (fp_accumulate_if.slave).
// Optional: FP_ACCUMULATE_RNE_EN selects round-nearest-even, else truncate.
module fp_accumulate #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = EXP + MANT + 1,
  parameter int CNT_W = 16
) (
  input  logic clock,
  input  logic clock_areset_n,
  input  logic clear,
  fp_accumulate_if.slave bus
);

  localparam int MW  = MANT + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = EXP + 2;
  localparam logic [EXP-1:0] MW_E  = EXP'(MW);
  localparam logic [EXP-1:0] E_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ALIGN,
    S_NORM,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_elem;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             r_sa;
  logic [EXP-1:0]   r_ea;
  logic [MW-1:0]    r_ma;
  logic [MW-1:0]    r_mb;
  logic             r_sub;
  logic             r_inf;
  logic             r_inf_s;

  // Align stage
  logic           w_acc_s;
  logic           w_el_s;
  logic [EXP-1:0] w_acc_e;
  logic [EXP-1:0] w_el_e;
  logic [MW-1:0]  w_acc_m;
  logic [MW-1:0]  w_el_m;
  logic           w_acc_inf;
  logic           w_el_inf;
  logic           w_swap;
  logic           w_sa;
  logic           w_sb;
  logic [EXP-1:0] w_ea;
  logic [EXP-1:0] w_eb;
  logic [MW-1:0]  w_ma;
  logic [MW-1:0]  w_mb;
  logic [EXP-1:0] w_delta;
  logic [MW-1:0]  w_mask;
  logic [MW-1:0]  w_mb_al;

  always_comb begin
    w_acc_s = r_acc[WIDTH-1];
    w_acc_e = r_acc[WIDTH-2 -: EXP];
    w_acc_m = '0;
    if (w_acc_e != '0)
      w_acc_m = {1'b1, r_acc[MANT-1:0], 3'b000};
    w_el_s = r_elem[WIDTH-1];
    w_el_e = r_elem[WIDTH-2 -: EXP];
    w_el_m = '0;
    if (w_el_e != '0)
      w_el_m = {1'b1, r_elem[MANT-1:0], 3'b000};
    w_acc_inf = &w_acc_e;
    w_el_inf  = &w_el_e;
    // exponent-then-mantissa magnitude compare
    w_swap = {w_el_e, w_el_m} > {w_acc_e, w_acc_m};
    if (w_swap) begin
      w_sa = w_el_s;
      w_ea = w_el_e;
      w_ma = w_el_m;
      w_sb = w_acc_s;
      w_eb = w_acc_e;
      w_mb = w_acc_m;
    end else begin
      w_sa = w_acc_s;
      w_ea = w_acc_e;
      w_ma = w_acc_m;
      w_sb = w_el_s;
      w_eb = w_el_e;
      w_mb = w_el_m;
    end
    w_delta = w_ea - w_eb;
    w_mask  = ~({MW{1'b1}} << w_delta);
    // far-out B collapses into the sticky bit
    if (w_delta >= MW_E)
      w_mb_al = {{(MW-1){1'b0}}, |w_mb};
    else
      w_mb_al = (w_mb >> w_delta)
              | {{(MW-1){1'b0}}, |(w_mb & w_mask)};
  end

  // Normalise stage
  logic [MW:0]      w_sum;
  logic [LZW-1:0]   w_lz;
  logic [MW-1:0]    w_nrm;
  logic [EW-1:0]    w_en;
  logic [EW-1:0]    w_ef;
  logic             w_inc;
  logic [MANT+1:0]  w_rnd;
  logic [MANT-1:0]  w_mf;
  logic [WIDTH-1:0] w_res;
  logic             w_res_ovf;
  logic             w_unused;

  always_comb begin
    if (r_sub)
      w_sum = {1'b0, r_ma} - {1'b0, r_mb};
    else
      w_sum = {1'b0, r_ma} + {1'b0, r_mb};
    w_lz = '0;
    for (int i = 0; i < MW; i++)
      if (w_sum[i])
        w_lz = LZW'(MW - 1 - i);
    if (w_sum[MW]) begin
      w_nrm = {w_sum[MW:2], w_sum[1] | w_sum[0]};
      w_en  = {2'b00, r_ea} + EW'(1);
    end else begin
      w_nrm = w_sum[MW-1:0] << w_lz;
      w_en  = {2'b00, r_ea}
            - {{(EW-LZW){1'b0}}, w_lz};
    end
`ifdef FP_ACCUMULATE_RNE_EN
    w_inc = w_nrm[2] & (w_nrm[1] | w_nrm[0] | w_nrm[3]);
`else
    w_inc = 1'b0;
`endif
    w_rnd = {2'b01, w_nrm[MW-2:3]}
          + {{(MANT+1){1'b0}}, w_inc};
    // rounding carry: mantissa wraps to 0, exponent +1
    if (w_rnd[MANT+1]) begin
      w_mf = w_rnd[MANT:1];
      w_ef = w_en + EW'(1);
    end else begin
      w_mf = w_rnd[MANT-1:0];
      w_ef = w_en;
    end
    w_res     = '0;
    w_res_ovf = 1'b0;
    if (r_inf) begin
      w_res     = {r_inf_s, E_MAX, {MANT{1'b0}}};
      w_res_ovf = 1'b1;
    end else if (w_sum == '0 || w_ef[EW-1] || w_ef == '0) begin
      w_res = '0;
    end else if (w_ef >= {2'b00, E_MAX}) begin
      w_res     = {r_sa, E_MAX, {MANT{1'b0}}};
      w_res_ovf = 1'b1;
    end else begin
      w_res = {r_sa, w_ef[EXP-1:0], w_mf};
    end
  end

  assign w_unused = ^{w_nrm[MW-1], w_nrm[2:0]};

  // FSM
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_count = '0;
    bus.out_ovf   = 1'b0;
    unique case (r_state)
      S_IDLE, S_READY: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          w_next = S_ALIGN;
      end
      S_ALIGN: w_next = S_NORM;
      S_NORM:  w_next = r_last ? S_OUT : S_READY;
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_acc;
        bus.out_count = r_cnt;
        bus.out_ovf   = r_ovf;
        if (bus.out_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (clear)
      w_next = S_IDLE;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_acc   <= '0;
      r_elem  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_sa    <= 1'b0;
      r_ea    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_sub   <= 1'b0;
      r_inf   <= 1'b0;
      r_inf_s <= 1'b0;
    end else if (clear) begin
      r_acc   <= '0;
      r_elem  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_sa    <= 1'b0;
      r_ea    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_sub   <= 1'b0;
      r_inf   <= 1'b0;
      r_inf_s <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_READY: begin
          if (bus.in_valid) begin
            r_elem <= bus.in_data;
            r_last <= bus.in_last;
            if (!(&r_cnt))
              r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          r_sa    <= w_sa;
          r_ea    <= w_ea;
          r_ma    <= w_ma;
          r_mb    <= w_mb_al;
          r_sub   <= w_sa ^ w_sb;
          // an inf anywhere pins the sum to inf
          r_inf   <= w_el_inf | w_acc_inf;
          r_inf_s <= w_el_inf ? w_el_s : w_acc_s;
        end
        S_NORM: begin
          r_acc <= w_res;
          r_ovf <= r_ovf | w_res_ovf;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_accumulate.md
Name: fp_accumulate

Overview:
- Parametrised floating-point stream accumulator for CNN dot-product reduction. It sums a packet of [s][e][m] values (in_last marks the end) into one result.
- Successor to the two-stage fp_add datapath. Adds valid/ready handshakes, packet framing, element counting, guard/round/sticky alignment, overflow saturation and optional RNE rounding.
- Sits between the multiplier array and the output writeback buffer.

Parameters:
- EXP, 8, exponent width.
- MANT, 7, stored mantissa width; the hidden 1 is implied.
- WIDTH, EXP+MANT+1, word width.
- CNT_W, 16, element-counter width.

Ports:
- clock  in  1  system clock
- clock_areset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  WIDTH  addend
- in_last  in  1  final element of the packet
- out_valid  out  1  packet result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  accumulated sum
- out_count  out  CNT_W  elements in the packet, saturating
- out_ovf  out  1  overflow/inf occurred in the packet

Behaviour:
- Reset (async, clock_areset_n=0), and clear=1 at a clock edge, both force:
  - state IDLE, accumulator +0, count 0, ovf 0;
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- clear has priority over every other input and aborts an in-flight element.
- FSM states: IDLE/READY -> ALIGN -> NORM -> (READY | OUT).
- READY:
  - in_ready=1.
  - On in_valid, capture in_data and in_last, increment count (saturating at all-ones), go to ALIGN.
- ALIGN (in_ready=0):
  - Operands are the accumulator and the captured element.
  - Swap so that the larger magnitude is operand A, comparing exponent first, then mantissa.
  - Extend both mantissas to hidden+MANT+3 bits (guard, round, sticky).
  - Shift B right by delta=eA-eB. Shifted-out bits OR into sticky. For delta ≥ MANT+4, B contributes sticky only.
- NORM (in_ready=0):
  - Add if the signs match, otherwise subtract.
  - Leading-zero normalise; handle a carry-out with a right shift by 1 and exponent +1.
  - Round per the optional feature. Rounding carry renormalises, exponent +1.
  - Write the result to the accumulator at the end of NORM.
  - Next state is OUT if the captured last=1, else READY.
- Timing: element accepted at edge T, accumulator updated at T+2, in_ready high again at T+3. Sustained throughput is 1 element per 3 cycles.
- OUT:
  - out_valid=1; out_data, out_count and out_ovf are held stable while out_ready=0. in_ready=0.
  - On out_ready, go to IDLE; accumulator, count and ovf are cleared for the next packet.
  - in_ready is not asserted in the same cycle as the output handshake.
- Operand and result rules:
  - Input with exponent 0 is treated as zero (denormals flushed, sign ignored).
  - Exact cancellation gives +0.
  - Result exponent underflow (≤0) flushes to +0.
  - Result exponent ≥ all-ones gives ±inf (exponent all-ones, mantissa 0) with the result sign, and sets ovf.
  - An input with exponent all-ones makes the accumulator ±inf with the input's sign and sets ovf. ovf is sticky until the packet is consumed.
- Single-element packet (in_last on the first element): out_data equals the input, or 0 if the input was zero or denormal.
- The first element of a packet adds into +0.

Optional Feature:
- Macro: FP_ACCUMULATE_RNE_EN.
- Defined: round-to-nearest-even using the guard/round/sticky bits.
  - Increment when G=1 and (R|S|lsb)=1.
  - Exact-tie cases go to the even mantissa.
- Undefined: truncate (round toward zero). Guard/round/sticky bits are discarded after normalisation, matching legacy fp_add precision.
- Latency and handshake are identical in both builds.

Test Plan:
- Sum: packet 0x3F80, 0x4000, 0x3F00(last) -> out_data=0x4060 (3.5), out_count=3, out_ovf=0.
- Cancellation: 0x3F80, 0xBF80(last) -> out_data=0x0000, out_count=2.
- Rounding: 0x4380 (256.0), 0x3FC0 (1.5, last) -> RNE build 0x4381 (258.0); truncate build 0x4380 (256.0).
- Overflow: 0x7F7F, 0x7F7F(last) -> out_data=0x7F80, out_ovf=1.
- Handshake timing: in_valid held high for a 4-element packet -> in_ready high exactly every third cycle; out_valid 3 cycles after the last accept.
  - Then hold out_ready=0 for 5 cycles -> out_valid, out_data and out_count stable, in_ready=0.
- Abort and reset: clear in ALIGN mid-packet -> next cycle in_ready=1, out_valid=0.
  - The following packet 0x4040(last) gives out_data=0x4040 with count 1.
  - clock_areset_n low mid-NORM -> all outputs reset immediately.
